mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequential initiator for the 32-word x 32-bit data memory (`mem`): accepts single or burst load/store requests from the datapath on a valid/ready channel. It drives the memory's `address`/`in`/`read` pins and returns read data on a backpressured response channel. It sits between the CPU datapath and `mem`, and is the only agent allowed to drive the memory pins.

## Interface
- `ADDR_W`, 5, word address width (32 words)
- `DATA_W`, 32, data width
- `LEN_W`, 3, burst length field width (beats = `req_len`+1, 1..8)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle, request accepted when both high
- `req_write`  in  1  1 = store burst, 0 = load burst
- `req_addr`  in  ADDR_W  start word address
- `req_len`  in  LEN_W  beats minus one
- `wd_valid` / `wd_ready`  in / out  1  store-data handshake
- `wd_data`  in  DATA_W  store beat data
- `rsp_valid` / `rsp_ready`  out / in  1  load-data handshake
- `rsp_data`  out  DATA_W  load beat data
- `rsp_last`  out  1  final beat of burst (qualified by `rsp_valid`)
- `wr_done`  out  1  one-cycle pulse after last store beat committed
- `err`  out  1  sticky readback mismatch (see Configuration)
- `mem_address`  out  ADDR_W  to `mem.address`
- `mem_in`  out  DATA_W  to `mem.in`
- `mem_read`  out  1  to `mem.read`; 0 writes memory combinationally
- `mem_out`  in  DATA_W  from `mem.out`

## Operation
- `mem` writes whenever `read`=0, so `mem_read` is 1 in every state except WCOMMIT; reset value 1.
- States: IDLE, RD, RSP, WR, WCOMMIT, VERIFY (VERIFY only with macro), WACK.
- IDLE: `req_ready`=1. On accept: latch `req_addr`→cur, `req_len`→remaining, clear `err`; `req_write` ? WR : RD.
- RD: `mem_address`=cur, `mem_read`=1; register `mem_out`→`rsp_data`; `rsp_last`=(remaining==0); →RSP.
- RSP: `rsp_valid`=1, `rsp_data`/`rsp_last` stable until accepted. On `rsp_ready`: remaining==0 → IDLE, else cur+1, remaining-1 → RD.
- WR: `wd_ready`=1. On `wd_valid`: register `wd_data`→`mem_in`; →WCOMMIT.
- WCOMMIT: `mem_read`=0 for exactly one cycle, `mem_address`=cur, `mem_in` stable. → VERIFY (macro) or next-beat logic: remaining==0 → WACK, else cur+1, remaining-1 → WR.
- WACK: `wr_done`=1 one cycle; →IDLE.
- Address arithmetic is modulo 32: cur 31 + 1 → 0 (burst wraps, no error).
- `mem_in` holds last store data outside WCOMMIT; `mem_address` holds cur.
- Reset (any time, mid-burst included): state IDLE, `mem_read`=1, all other outputs 0, `rsp_data`/`mem_in`/`mem_address` 0; the partial burst is abandoned and no write pulse is emitted.

## Timing
- Load: accept at edge 0 → RD in cycle 1 → `rsp_valid` from cycle 2. One beat per 2 cycles with `rsp_ready` held high; 8-beat burst returns last beat at cycle 16.
- Store: accept at edge 0 → WR cycle 1 → write pulse cycle 2 (if `wd_valid` high in cycle 1). One beat per 2 cycles (3 with macro); `wr_done` one cycle after the last WCOMMIT/VERIFY.
- `req_ready` low from the cycle after accept until back in IDLE; no request overlap.
- `rsp_valid` never drops without `rsp_ready`; `wd_ready` only in WR.

## Configuration
- `MEM_CTRL_READBACK_EN` defined: after each WCOMMIT, VERIFY reads cur (`mem_read`=1) and compares `mem_out` with `mem_in`; a mismatch sets `err`, which stays sticky until the next request is accepted. VERIFY then applies the next-beat logic.
- Undefined: no VERIFY state, `err` tied 0.

## Structure
- Shared package `mem_ctrl_pkg`: state encoding constants, `ADDR_W`/`DATA_W`/`LEN_W` defaults, `MEM_WORDS`=32.
- One sub-module `mem_ctrl_beat_cnt`: loadable wrap-around address counter plus remaining-beat down-counter with `last` flag.

## Test plan
- Reset with `rst_n`=0 → `mem_read`=1, `req_ready`=0 during reset and 1 after release, every other output 0.
- Store addr 3, len 0, `wd_data`=32'hDEADBEEF → exactly one cycle `mem_read`=0 at address 3, `wr_done` pulses; a following load at addr 3 returns DEADBEEF with `rsp_last`=1.
- Store burst addr 30, len 3, data 1..4 → addresses 30, 31, 0, 1 written; load burst addr 30 len 3 returns 1, 2, 3, 4, `rsp_last` on 4th.
- Load burst with `rsp_ready` low 5 cycles on beat 2 → `rsp_data`/`rsp_last` stable, no address advance, no memory write.
- Assert `rst_n` low mid-store-burst after beat 1 → IDLE immediately; only beat 1 is in memory.
- With `MEM_CTRL_READBACK_EN`, bench forces `mem_out`≠`mem_in` during VERIFY → `err`=1 until the next request is accepted; without the macro, `err` stays 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the mem_ctrl sequential memory initiator.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 3;
  localparam int MEM_WORDS  = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RSP     = 3'd2,
    S_WR      = 3'd3,
    S_WCOMMIT = 3'd4,
    S_VERIFY  = 3'd5,
    S_WACK    = 3'd6
  } state_t;

endpackage

// File: rtl/mem_ctrl_beat_cnt.sv
// Burst bookkeeping for mem_ctrl: loadable wrap-around word address counter
// plus remaining-beat down-counter with a last-beat flag.
module mem_ctrl_beat_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  logic [LEN_W-1:0] remaining;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order between processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      // Bursts running past the top word wrap to word 0 without complaint.
      addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Sequential load/store initiator for the 32x32 data memory; sole driver of its pins.
// Optional write readback check enabled by defining MEM_CTRL_READBACK_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out
);

  state_t state, next_state;
  logic   load, step, last, accept;

  mem_ctrl_beat_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_beat_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (mem_address),
    .last      (last)
  );

  assign accept = req_valid && req_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          next_state = req_write ? S_WR : S_RD;
        end
      end
      S_RD: next_state = S_RSP;
      S_RSP: begin
        if (rsp_ready) begin
          next_state = last ? S_IDLE : S_RD;
          step       = !last;
        end
      end
      S_WR: begin
        if (wd_valid) next_state = S_WCOMMIT;
      end
`ifdef MEM_CTRL_READBACK_EN
      S_WCOMMIT: next_state = S_VERIFY;
      S_VERIFY: begin
        next_state = last ? S_WACK : S_WR;
        step       = !last;
      end
`else
      S_WCOMMIT: begin
        next_state = last ? S_WACK : S_WR;
        step       = !last;
      end
`endif
      S_WACK:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // mem writes whenever read is low, so the strobe comes straight from a flop
  // to keep decode glitches off the memory pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      mem_read  <= 1'b1;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      mem_in    <= '0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      mem_read  <= (next_state != S_WCOMMIT);
      if (state == S_RD) begin
        rsp_data <= mem_out;
        rsp_last <= last;
      end
      if (state == S_WR && wd_valid) mem_in <= wd_data;
    end
  end

  assign rsp_valid = (state == S_RSP);
  assign wd_ready  = (state == S_WR);
  assign wr_done   = (state == S_WACK);

`ifdef MEM_CTRL_READBACK_EN
  // Sticky until the next accepted request; a new request always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (load) begin
      err <= 1'b0;
    end else if (state == S_VERIFY && mem_out != mem_in) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural 32x32 memory, response and write scoreboards.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int GAP = RB ? 2 : 1;

  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {logic [31:0] d; logic last;} rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [2:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic        wr_done, err;
  logic [4:0]  mem_address;
  logic [31:0] mem_in, mem_out;
  logic        mem_read;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_model [32];
  bit          written   [32];
  logic [31:0] ref_mem   [32];
  logic [31:0] sdata     [8];
  bit          corrupt;
  wr_t         exp_wr [$];
  rsp_t        exp_rsp [$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wd_valid    (wd_valid),
    .wd_ready    (wd_ready),
    .wd_data     (wd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .wr_done     (wr_done),
    .err         (err),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_read    (mem_read),
    .mem_out     (mem_out)
  );

  function automatic logic [31:0] init_word(input logic [4:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Memory writes combinationally while read is low, like the real macro.
  always @(mem_read or mem_address or mem_in) begin
    if (mem_read === 1'b0) begin
      mem_model[mem_address] = mem_in;
      written[mem_address]   = 1'b1;
    end
  end

  logic [31:0] mem_word;
  assign mem_word = written[mem_address] ? mem_model[mem_address] : init_word(mem_address);
  assign mem_out  = corrupt ? ~mem_word : mem_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each low-read cycle must match the next queued store beat.
  always @(negedge clk) begin
    if (mem_read !== 1'b1) begin
      check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        wr_t w;
        w = exp_wr.pop_front();
        check("write_addr", 32'(mem_address), 32'(w.a));
        check("write_data", mem_in, w.d);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"},  32'(mem_read),    32'd1);
    check({tag, "_req_ready"}, 32'(req_ready),   32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid),   32'd0);
    check({tag, "_rsp_last"},  32'(rsp_last),    32'd0);
    check({tag, "_rsp_data"},  rsp_data,         32'd0);
    check({tag, "_wd_ready"},  32'(wd_ready),    32'd0);
    check({tag, "_wr_done"},   32'(wr_done),     32'd0);
    check({tag, "_err"},       32'(err),         32'd0);
    check({tag, "_mem_addr"},  32'(mem_address), 32'd0);
    check({tag, "_mem_in"},    mem_in,           32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic issue_req(input logic w, input logic [4:0] a, input logic [2:0] l);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic do_store(input logic [4:0] a, input logic [2:0] l);
    int n;
    wr_t w;
    issue_req(1'b1, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      n = 0;
      while (wd_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("wd_ready", 32'(wd_ready), 32'd1);
      check("wr_beat_gap", 32'(n), (b == 0) ? 32'd0 : 32'(GAP));
      w.a = 5'(a + 5'(b));
      w.d = sdata[b];
      exp_wr.push_back(w);
      ref_mem[w.a] = w.d;
      wd_valid = 1'b1;
      wd_data  = sdata[b];
      @(negedge clk);
      wd_valid = 1'b0;
    end
    n = 0;
    while (wr_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_done_set", 32'(wr_done), 32'd1);
    check("wr_done_lat", 32'(n), 32'(GAP));
    @(negedge clk);
    check("wr_done_pulse", 32'(wr_done), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic do_load(input logic [4:0] a, input logic [2:0] l, input int stall_beat, input int stall_cycles);
    int n;
    rsp_t r;
    for (int b = 0; b <= int'(l); b++) begin
      r.d    = ref_mem[5'(a + 5'(b))];
      r.last = (b == int'(l));
      exp_rsp.push_back(r);
    end
    issue_req(1'b0, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_gap", 32'(n), 32'd1);
      check("rsp_addr", 32'(mem_address), 32'(5'(a + 5'(b))));
      if (b == stall_beat) begin
        rsp_ready = 1'b0;
        repeat (stall_cycles) begin
          @(negedge clk);
          check("stall_valid", 32'(rsp_valid), 32'd1);
          check("stall_data", rsp_data, exp_rsp[0].d);
          check("stall_last", 32'(rsp_last), 32'(exp_rsp[0].last));
          check("stall_addr", 32'(mem_address), 32'(5'(a + 5'(b))));
          check("stall_no_write", 32'(mem_read), 32'd1);
        end
        rsp_ready = 1'b1;
      end
      r = exp_rsp.pop_front();
      check("rsp_data", rsp_data, r.d);
      check("rsp_last", 32'(rsp_last), 32'(r.last));
      @(negedge clk);
    end
    check("load_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    wr_t w;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    rsp_ready = 1'b1;
    corrupt   = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(5'(i));

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("read_after_reset", 32'(mem_read), 32'd1);

    // Single store then load back.
    sdata[0] = 32'hDEAD_BEEF;
    do_store(5'd3, 3'd0);
    do_load(5'd3, 3'd0, -1, 0);

    // Burst wrapping past word 31, then plain and stalled read-back.
    for (int i = 0; i < 4; i++) sdata[i] = 32'(i + 1);
    do_store(5'd30, 3'd3);
    do_load(5'd30, 3'd3, -1, 0);
    do_load(5'd30, 3'd3, 1, 5);

    // Maximum-length load.
    do_load(5'd0, 3'd7, -1, 0);

    // Reset mid store burst after the first beat is committed.
    issue_req(1'b1, 5'd10, 3'd3);
    n = 0;
    while (wd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_wd_ready", 32'(wd_ready), 32'd1);
    w.a = 5'd10;
    w.d = 32'hA1A1_0001;
    exp_wr.push_back(w);
    ref_mem[10] = w.d;
    wd_valid = 1'b1;
    wd_data  = w.d;
    @(negedge clk);
    wd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    do_load(5'd10, 3'd1, -1, 0);

    // Readback corruption: err only exists with the readback build.
    sdata[0] = 32'h1234_5678;
    corrupt  = 1'b1;
    do_store(5'd5, 3'd0);
    corrupt  = 1'b0;
    check("err_after_store", 32'(err), 32'(RB));
    @(negedge clk);
    check("err_sticky", 32'(err), 32'(RB));
    do_load(5'd5, 3'd0, -1, 0);
    check("err_after_load", 32'(err), 32'd0);

    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("rsps_drained", 32'(exp_rsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
